// File: rtl/alu_acc.sv
// Accumulator ALU: single-cycle ops plus optional sequential shift-add multiply.
// Define ALU_ACC_MUL_EN to build the MUL opcode (10); otherwise it decodes as undefined.
module alu_acc #(
    parameter int WIDTH     = 8,
    parameter int MUL_CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       aluOpe,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry,
    output logic             err
);

    typedef enum logic [3:0] {
        OP_MOVE = 4'd0,
        OP_INC  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_NOT  = 4'd7,
        OP_SHL  = 4'd8,
        OP_SHR  = 4'd9,
        OP_MUL  = 4'd10
    } op_e;

    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("alu_acc: WIDTH must be within 4..32");
    end
    if (MUL_CNT_W < $clog2(WIDTH + 1)) begin : g_bad_cnt_w
        $error("alu_acc: MUL_CNT_W too narrow to count WIDTH iterations");
    end

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept;
    logic             wr;
    logic [WIDTH-1:0] res;
    logic             res_cy;
    logic [WIDTH:0]   sum;
    logic             mul_fin;

`ifdef ALU_ACC_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e                 state_q, state_d;
    logic [MUL_CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;

    assign busy = (state_q == S_MUL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    // One partial product per cycle; the finished product is consumed
    // combinationally on the last iteration so acc updates as busy falls.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        mul_fin  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && aluOpe == OP_MUL) begin
                    state_d  = S_MUL;
                    cnt_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, acc_q};
                    mplier_d = data;
                    prod_d   = '0;
                end
            end
            S_MUL: begin
                prod_d   = mplier_q[0] ? prod_q + mcand_q : prod_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + MUL_CNT_W'(1);
                if (cnt_d == MUL_CNT_W'(WIDTH)) begin
                    state_d = S_IDLE;
                    mul_fin = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
`else
    assign busy    = 1'b0;
    assign mul_fin = 1'b0;
`endif

    assign accept = start && !busy;

    always_comb begin
        acc_d   = acc_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr      = 1'b0;
        res     = acc_q;
        res_cy  = 1'b0;
        sum     = '0;
        if (accept) begin
            case (aluOpe)
                OP_MOVE: begin
                    res = data;
                    wr  = 1'b1;
                end
                OP_INC: begin
                    sum    = {1'b0, acc_q} + (WIDTH+1)'(1);
                    res    = sum[WIDTH-1:0];
                    res_cy = sum[WIDTH];
                    wr     = 1'b1;
                end
                OP_ADD: begin
                    sum    = {1'b0, acc_q} + {1'b0, data};
                    res    = sum[WIDTH-1:0];
                    res_cy = sum[WIDTH];
                    wr     = 1'b1;
                end
                OP_SUB: begin
                    res    = acc_q - data;
                    res_cy = (acc_q < data);
                    wr     = 1'b1;
                end
                OP_AND: begin
                    res = acc_q & data;
                    wr  = 1'b1;
                end
                OP_OR: begin
                    res = acc_q | data;
                    wr  = 1'b1;
                end
                OP_XOR: begin
                    res = acc_q ^ data;
                    wr  = 1'b1;
                end
                OP_NOT: begin
                    res = ~acc_q;
                    wr  = 1'b1;
                end
                OP_SHL: begin
                    res    = {acc_q[WIDTH-2:0], 1'b0};
                    res_cy = acc_q[WIDTH-1];
                    wr     = 1'b1;
                end
                OP_SHR: begin
                    res    = {1'b0, acc_q[WIDTH-1:1]};
                    res_cy = acc_q[0];
                    wr     = 1'b1;
                end
`ifdef ALU_ACC_MUL_EN
                OP_MUL: ;
`endif
                default: begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end
            endcase
        end
`ifdef ALU_ACC_MUL_EN
        if (mul_fin) begin
            res    = prod_d[WIDTH-1:0];
            res_cy = |prod_d[2*WIDTH-1:WIDTH];
            wr     = 1'b1;
        end
`endif
        if (wr) begin
            acc_d   = res;
            carry_d = res_cy;
            zero_d  = (res == '0);
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign acc   = acc_q;
    assign zero  = zero_q;
    assign carry = carry_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_alu_acc.sv
// Self-checking bench for alu_acc (WIDTH=8): directed table, corner sequences, random vs model.
module tb_alu_acc;

    localparam int W    = 8;
    localparam int MASK = 255;
`ifdef ALU_ACC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   aluOpe = '0;
    logic [W-1:0] data = '0;
    logic [W-1:0] acc;
    logic         busy, done, zero, carry, err;

    int checks = 0;
    int errors = 0;

    alu_acc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .aluOpe(aluOpe), .data(data),
        .acc(acc), .busy(busy), .done(done), .zero(zero), .carry(carry), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for its done pulse.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] d, output int lat);
        @(negedge clk);
        start  = 1'b1;
        aluOpe = op;
        data   = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Reference: plain integer arithmetic on the opcode's definition.
    function automatic void model(input int op, input int a, input int b, input int c_prev,
                                  output int r, output int c, output bit e);
        int t;
        e = 1'b0;
        r = a;
        c = 0;
        case (op)
            0: r = b;
            1: begin t = a + 1; r = t % 256; c = (t > MASK); end
            2: begin t = a + b; r = t % 256; c = (t > MASK); end
            3: begin r = (a - b + 256) % 256; c = (a < b); end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            7: r = MASK - a;
            8: begin t = a * 2; r = t % 256; c = (t > MASK); end
            9: begin r = a / 2; c = a % 2; end
            10: begin
                if (MUL_EN) begin
                    t = a * b; r = t % 256; c = (t / 256) != 0;
                end else begin
                    e = 1'b1; c = c_prev;
                end
            end
            default: begin e = 1'b1; c = c_prev; end
        endcase
    endfunction

    typedef struct {
        logic [3:0] op;
        logic [7:0] pre;
        logic [7:0] d;
        logic [7:0] exp_acc;
        logic       exp_c;
        logic       exp_z;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat;
        int busy_cycles;
        int done_cnt;
        int acc_m, c_m, z_m, r, c;
        bit e;
        int op, d;

        vecs.push_back('{4'h0, 8'h00, 8'hAA, 8'hAA, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h1, 8'h0F, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h2, 8'h03, 8'h05, 8'h08, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h3, 8'h08, 8'h02, 8'h06, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h4, 8'hAA, 8'hCC, 8'h88, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h5, 8'hAA, 8'hCC, 8'hEE, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h6, 8'hAA, 8'hCC, 8'h66, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h7, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{4'h3, 8'h02, 8'h03, 8'hFF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{4'h8, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{4'h9, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{4'hF, 8'h5A, 8'h33, 8'h5A, 1'b0, 1'b0, 1'b1});
        if (!MUL_EN) vecs.push_back('{4'hA, 8'h3C, 8'h02, 8'h3C, 1'b0, 1'b0, 1'b1});

        // Power-on reset state
        #12;
        chk("reset acc", acc, 0);
        chk("reset zero", zero, 1);
        chk("reset carry", carry, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed single-cycle table
        foreach (vecs[i]) begin
            run_op(4'h0, vecs[i].pre, lat);
            run_op(vecs[i].op, vecs[i].d, lat);
            chk($sformatf("v%0d latency", i), lat, 1);
            chk($sformatf("v%0d acc", i), acc, vecs[i].exp_acc);
            chk($sformatf("v%0d carry", i), carry, vecs[i].exp_c);
            chk($sformatf("v%0d zero", i), zero, vecs[i].exp_z);
            chk($sformatf("v%0d err", i), err, vecs[i].exp_err);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d done low", i), done, 0);
            chk($sformatf("v%0d err low", i), err, 0);
        end

        // Asynchronous reset mid-cycle, no clock edge in between
        run_op(4'h0, 8'hC3, lat);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst acc", acc, 0);
        chk("async rst zero", zero, 1);
        chk("async rst carry", carry, 0);
        chk("async rst busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

`ifdef ALU_ACC_MUL_EN
        // 0C * 0B with ignored start pulses while busy
        run_op(4'h0, 8'h0C, lat);
        @(negedge clk);
        start = 1'b1; aluOpe = 4'hA; data = 8'h0B;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_cycles = 0;
        done_cnt = 0;
        while (busy && busy_cycles < 40) begin
            busy_cycles++;
            done_cnt += done;
            @(negedge clk);
            start = busy_cycles[0]; aluOpe = 4'h0; data = 8'hFF;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("mul busy cycles", busy_cycles, W);
        chk("mul done at end", done, 1);
        chk("mul done while busy", done_cnt, 0);
        chk("mul acc", acc, 8'h84);
        chk("mul carry", carry, 0);
        chk("mul zero", zero, 0);
        @(posedge clk);
        #1;
        chk("mul done low", done, 0);
        chk("mul acc hold", acc, 8'h84);

        run_op(4'h0, 8'h10, lat);
        run_op(4'hA, 8'h10, lat);
        chk("mul2 latency", lat, W + 1);
        chk("mul2 acc", acc, 0);
        chk("mul2 carry", carry, 1);
        chk("mul2 zero", zero, 1);

        // Reset during the fourth iteration
        run_op(4'h0, 8'h07, lat);
        @(negedge clk);
        start = 1'b1; aluOpe = 4'hA; data = 8'h03;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mulrst acc", acc, 0);
        chk("mulrst busy", busy, 0);
        chk("mulrst zero", zero, 1);
        done_cnt = done;
        repeat (3) begin
            @(posedge clk);
            #1;
            done_cnt += done;
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        done_cnt += done;
        chk("mulrst no done", done_cnt, 0);
        chk("mulrst acc after", acc, 0);
        run_op(4'h0, 8'h07, lat);
        chk("post-rst accept", lat, 1);
        run_op(4'hA, 8'h03, lat);
        chk("mul3 latency", lat, W + 1);
        chk("mul3 acc", acc, 8'h15);
        chk("mul3 carry", carry, 0);
`else
        run_op(4'h0, 8'h44, lat);
        @(negedge clk);
        start = 1'b1; aluOpe = 4'hA; data = 8'h02;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("op A busy", busy, 0);
        chk("op A err", err, 1);
        chk("op A acc", acc, 8'h44);
`endif

        // Randomized operations against the reference model
        d = $urandom_range(0, MASK);
        run_op(4'h0, W'(d), lat);
        acc_m = d; c_m = 0; z_m = (d == 0);
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 15);
            d  = $urandom_range(0, MASK);
            model(op, acc_m, d, c_m, r, c, e);
            if (!e) begin
                acc_m = r; c_m = c; z_m = (r == 0);
            end
            run_op(4'(op), W'(d), lat);
            chk($sformatf("rnd%0d op%0d latency", n, op), lat,
                (op == 10 && MUL_EN) ? W + 1 : 1);
            chk($sformatf("rnd%0d op%0d acc", n, op), acc, acc_m);
            chk($sformatf("rnd%0d op%0d carry", n, op), carry, c_m);
            chk($sformatf("rnd%0d op%0d zero", n, op), zero, z_m);
            chk($sformatf("rnd%0d op%0d err", n, op), err, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_acc.md
ALU_ACC -- requirements
Module: alu_acc

Interface
REQ-001 SHALL have parameter WIDTH, 8, datapath and accumulator width (legal range 4..32).
REQ-002 SHALL have parameter MUL_CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  operation request, sampled on the rising edge while busy=0.
REQ-006 SHALL have port aluOpe  input  4  opcode, sampled with start.
REQ-007 SHALL have port data  input  WIDTH  operand B, sampled with start.
REQ-008 SHALL have port acc  output  WIDTH  registered accumulator (operand A and result).
REQ-009 SHALL have port busy  output  1  high while a multi-cycle operation executes.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a result is written.
REQ-011 SHALL have port zero  output  1  registered flag: last result == 0.
REQ-012 SHALL have port carry  output  1  registered carry/borrow/shift-out flag.
REQ-013 SHALL have port err  output  1  one-cycle pulse with done for an undefined opcode.

Function
REQ-014 SHALL decode opcodes: 0 MOVE acc<=data; 1 INC acc<=acc+1; 2 ADD acc<=acc+data; 3 SUB acc<=acc-data; 4 AND; 5 OR; 6 XOR (bitwise acc op data); 7 NOT acc<=~acc; 8 SHL by 1; 9 SHR by 1 (logical); 10 MUL; 11-15 undefined.
REQ-015 SHALL complete opcodes 0-9 and undefined opcodes in one cycle: start at edge N -> acc/flags updated and done=1 after edge N, done=0 after edge N+1.
REQ-016 SHALL implement MUL as sequential shift-add over exactly WIDTH iterations: busy=1 from edge N through the WIDTH-th iteration; acc<=low WIDTH bits of acc*data; done pulses on the cycle busy falls.
REQ-017 SHALL use FSM states IDLE (accept start) and MUL (iterate); IDLE->MUL on start with opcode 10; MUL->IDLE when the iteration counter reaches WIDTH.
REQ-018 SHALL ignore start while busy=1 (no queuing, no effect on the running operation).
REQ-019 SHALL set carry: ADD/INC = carry-out; SUB = borrow (acc<data); SHL = old MSB; SHR = old LSB; MUL = OR of high WIDTH product bits; MOVE/logic/NOT = 0.
REQ-020 SHALL set zero = (new acc == 0) on every completed operation.
REQ-021 SHALL wrap arithmetic modulo 2^WIDTH (INC of all-ones -> 0, carry=1, zero=1).
REQ-022 SHALL leave acc, zero and carry unchanged and pulse err with done for an undefined opcode.
REQ-023 SHALL hold acc, zero, carry stable when no operation completes.

Reset
REQ-024 SHALL on rst=1, regardless of clock, force acc=0, zero=1, carry=0, busy=0, done=0, err=0, FSM=IDLE, counter=0.
REQ-025 SHALL abort an in-progress MUL on reset with no done pulse and no partial result visible.
REQ-026 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL compile MUL (opcode 10, state MUL, counter, multiplicand/product registers) only when macro ALU_ACC_MUL_EN is defined.
REQ-028 SHALL without ALU_ACC_MUL_EN treat opcode 10 as undefined (per REQ-022); busy is then tied 0.

Verification
REQ-029 SHALL verify reset: assert rst mid-cycle -> acc=00, zero=1, carry=0, busy=0 immediately, no clock needed.
REQ-030 SHALL verify single-cycle ops (WIDTH=8): MOVE AA -> acc=AA; acc=0F INC -> 10; acc=03 ADD 05 -> 08; acc=08 SUB 02 -> 06; acc=AA AND CC -> 88, OR -> EE, XOR -> 66; acc=0F NOT -> F0; each done=1 for exactly one cycle after start.
REQ-031 SHALL verify boundaries: acc=FF INC -> 00, carry=1, zero=1; acc=02 SUB 03 -> FF, carry=1; acc=81 SHL -> 02, carry=1; SHR of 01 -> 00, carry=1, zero=1.
REQ-032 SHALL verify MUL (macro defined): acc=0C MUL 0B -> busy=1 for 8 cycles, then acc=84, carry=0, one done; acc=10 MUL 10 -> acc=00, carry=1, zero=1; start pulses during busy change nothing.
REQ-033 SHALL verify reset mid-MUL: rst at iteration 4 -> acc=00, busy=0, no done; next MUL completes correctly.
REQ-034 SHALL verify undefined opcode 0xF (and 0xA with macro undefined): acc unchanged, done=1 and err=1 for one cycle.
